// File: rtl/key_dir_decoder.sv
// PS/2 set-2 arrow-key decoder: held levels plus one-cycle press pulses.
// Optional auto-repeat of the most recently pressed key is enabled by defining KEY_AUTOREPEAT_EN.
module key_dir_decoder #(
    parameter int TIMEOUT       = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic       up,
    output logic       down,
    output logic       right,
    output logic       left,
    output logic       up_p,
    output logic       down_p,
    output logic       right_p,
    output logic       left_p
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic [TW-1:0] tmo_q;
    logic [3:0]    lvl_q;    // {right, left, down, up}
    logic [3:0]    pls_q;
    logic [3:0]    arrow_oh;
    logic [3:0]    press_oh;
    logic [3:0]    new_oh;
    logic [3:0]    rel_oh;
    logic [3:0]    rep_oh;

    always_comb begin
        arrow_oh = 4'b0000;
        case (din)
            8'h75:   arrow_oh = 4'b0001;
            8'h72:   arrow_oh = 4'b0010;
            8'h6B:   arrow_oh = 4'b0100;
            8'h74:   arrow_oh = 4'b1000;
            default: arrow_oh = 4'b0000;
        endcase
    end

    assign press_oh = (din_new && state_q == S_EXT)     ? arrow_oh : 4'b0000;
    assign rel_oh   = (din_new && state_q == S_EXT_BRK) ? arrow_oh : 4'b0000;
    // Only a 0->1 level transition pulses, so typematic makes stay silent.
    assign new_oh   = press_oh & ~lvl_q;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [3:0]    rep_key_q;
    logic [RW-1:0] rep_cnt_q;

    assign rep_oh = (rep_cnt_q == '0 && new_oh == 4'b0000) ? (rep_key_q & ~rel_oh) : 4'b0000;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rep_key_q <= 4'b0000;
            rep_cnt_q <= '0;
        end else if (new_oh != 4'b0000) begin
            rep_key_q <= new_oh;
            rep_cnt_q <= RW'(REPEAT_DELAY - 1);
        end else if ((rep_key_q & rel_oh) != 4'b0000) begin
            rep_key_q <= 4'b0000;
            rep_cnt_q <= '0;
        end else if (rep_key_q != 4'b0000) begin
            if (rep_cnt_q == '0) rep_cnt_q <= RW'(REPEAT_PERIOD - 1);
            else                 rep_cnt_q <= rep_cnt_q - 1'b1;
        end
    end
`else
    assign rep_oh = 4'b0000;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            lvl_q   <= 4'b0000;
            pls_q   <= 4'b0000;
        end else begin
            lvl_q <= (lvl_q | press_oh) & ~rel_oh;
            pls_q <= new_oh | rep_oh;
            if (din_new) begin
                // A byte in the expiry cycle wins over the timeout.
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (din == 8'hE0)      state_q <= S_EXT;
                        else if (din == 8'hF0) state_q <= S_BRK;
                        else                   state_q <= S_IDLE;
                    end
                    S_EXT: begin
                        if (din == 8'hF0)      state_q <= S_EXT_BRK;
                        else if (din == 8'hE0) state_q <= S_EXT;
                        else                   state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE) begin
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_q <= S_IDLE;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign up      = lvl_q[0];
    assign down    = lvl_q[1];
    assign left    = lvl_q[2];
    assign right   = lvl_q[3];
    assign up_p    = pls_q[0];
    assign down_p  = pls_q[1];
    assign left_p  = pls_q[2];
    assign right_p = pls_q[3];

endmodule

// File: tb/tb_key_dir_decoder.sv
// Directed bench for key_dir_decoder; vectors are {right,left,down,up}.
module tb_key_dir_decoder;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_new = 1'b0;
    logic       up, down, right, left, up_p, down_p, right_p, left_p;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic [3:0] lvl;
        logic [3:0] pls;
    } vec_t;

    vec_t vt[$];

    key_dir_decoder #(.TIMEOUT(16), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
        .clk(clk), .resetN(resetN), .din(din), .din_new(din_new),
        .up(up), .down(down), .right(right), .left(left),
        .up_p(up_p), .down_p(down_p), .right_p(right_p), .left_p(left_p)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lvl_v();
        return {right, left, down, up};
    endfunction

    function automatic logic [3:0] pls_v();
        return {right_p, left_p, down_p, up_p};
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Strobe one byte for one cycle; returns #1 after the sampling edge.
    task automatic send(input logic [7:0] b);
        din = b;
        din_new = 1'b1;
        @(posedge clk); #1;
        din_new = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        chk("reset_lvl", lvl_v(), 4'b0000);
        chk("reset_pls", pls_v(), 4'b0000);
        resetN = 1'b1;
        idle(1);

`ifdef KEY_AUTOREPEAT_EN
        send(8'hE0);
        send(8'h75);
        chk("rep_press", pls_v(), 4'b0001);
        for (int k = 1; k < 20; k++) begin
            idle(1);
            chk($sformatf("rep_k%0d", k), pls_v(), (k == 10 || k == 14 || k == 18) ? 4'b0001 : 4'b0000);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("rep_rel_lvl", lvl_v(), 4'b0000);
        chk("rep_rel_pls", pls_v(), 4'b0000);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            chk($sformatf("rep_after_%0d", k), pls_v(), 4'b0000);
        end
`else
        vt.push_back('{8'hE0, 4'b0000, 4'b0000});
        vt.push_back('{8'h75, 4'b0001, 4'b0001});
        vt.push_back('{8'hE0, 4'b0001, 4'b0000});
        vt.push_back('{8'h75, 4'b0001, 4'b0000});
        vt.push_back('{8'hE0, 4'b0001, 4'b0000});
        vt.push_back('{8'hF0, 4'b0001, 4'b0000});
        vt.push_back('{8'h75, 4'b0000, 4'b0000});
        vt.push_back('{8'hE0, 4'b0000, 4'b0000});
        vt.push_back('{8'h6B, 4'b0100, 4'b0100});
        vt.push_back('{8'hE0, 4'b0100, 4'b0000});
        vt.push_back('{8'h74, 4'b1100, 4'b1000});
        vt.push_back('{8'hF0, 4'b1100, 4'b0000});
        vt.push_back('{8'h6B, 4'b1100, 4'b0000});
        vt.push_back('{8'hE0, 4'b1100, 4'b0000});
        vt.push_back('{8'hE0, 4'b1100, 4'b0000});
        vt.push_back('{8'h72, 4'b1110, 4'b0010});
        vt.push_back('{8'h75, 4'b1110, 4'b0000});
        vt.push_back('{8'hE0, 4'b1110, 4'b0000});
        vt.push_back('{8'h1C, 4'b1110, 4'b0000});
        vt.push_back('{8'h75, 4'b1110, 4'b0000});
        vt.push_back('{8'hE0, 4'b1110, 4'b0000});
        vt.push_back('{8'hF0, 4'b1110, 4'b0000});
        vt.push_back('{8'h6B, 4'b1010, 4'b0000});
        vt.push_back('{8'hE0, 4'b1010, 4'b0000});
        vt.push_back('{8'hF0, 4'b1010, 4'b0000});
        vt.push_back('{8'h74, 4'b0010, 4'b0000});
        vt.push_back('{8'hF0, 4'b0010, 4'b0000});
        vt.push_back('{8'hE0, 4'b0010, 4'b0000});
        vt.push_back('{8'h75, 4'b0010, 4'b0000});
        vt.push_back('{8'hE0, 4'b0010, 4'b0000});
        vt.push_back('{8'hF0, 4'b0010, 4'b0000});
        vt.push_back('{8'h72, 4'b0000, 4'b0000});
        vt.push_back('{8'hE0, 4'b0000, 4'b0000});
        vt.push_back('{8'h6B, 4'b0100, 4'b0100});

        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].b);
            chk($sformatf("vec%0d_lvl", i), lvl_v(), vt[i].lvl);
            chk($sformatf("vec%0d_pls", i), pls_v(), vt[i].pls);
            idle(1);
            chk($sformatf("vec%0d_pw", i), pls_v(), 4'b0000);
        end

        // EXT timeout: 16 silent cycles drop back to IDLE, left stays held.
        send(8'hE0);
        idle(16);
        send(8'h75);
        chk("tmo_ext_lvl", lvl_v(), 4'b0100);
        chk("tmo_ext_pls", pls_v(), 4'b0000);
        send(8'hE0);
        send(8'h72);
        chk("tmo_next_lvl", lvl_v(), 4'b0110);
        chk("tmo_next_pls", pls_v(), 4'b0010);

        // Byte arriving in the expiry cycle is still processed in EXT.
        send(8'hE0);
        idle(15);
        send(8'h75);
        chk("tmo_edge_lvl", lvl_v(), 4'b0111);
        chk("tmo_edge_pls", pls_v(), 4'b0001);

        // EXT_BRK timeout: the late 6B must not release left.
        send(8'hE0);
        send(8'hF0);
        idle(16);
        send(8'h6B);
        chk("tmo_brk_lvl", lvl_v(), 4'b0111);

        // Reset mid-sequence.
        send(8'hE0);
        resetN = 1'b0;
        #1;
        chk("rst_async_lvl", lvl_v(), 4'b0000);
        chk("rst_async_pls", pls_v(), 4'b0000);
        @(posedge clk); #1;
        resetN = 1'b1;
        send(8'h75);
        chk("rst_mid_lvl", lvl_v(), 4'b0000);
        chk("rst_mid_pls", pls_v(), 4'b0000);
        send(8'hE0);
        send(8'h75);
        chk("rst_after_lvl", lvl_v(), 4'b0001);
        chk("rst_after_pls", pls_v(), 4'b0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
